// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences each instruction
// through fetch/decode/execute/memory/writeback over one shared memory port.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pcsrc,
    output logic       reg_we,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = S_FETCH;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pcsrc      = 2'b00;
        reg_we     = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_R:           state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEXEC;
                    OP_J:           state_d = S_JUMP;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we     = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                pc_we      = (opcode == OP_BNE) ? ~zero : zero;
                instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_we      = 1'b1;
                pcsrc      = 2'b10;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset abandons the instruction: no side effects reach the datapath.
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            reg_we     = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table plus randomized
// instruction stream checked against a per-instruction phase-plan model.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwe, iord, irwe, pcwe;
        logic [1:0] pcsrc;
        logic       regwe, regdst, m2r, asa;
        logic [1:0] asb, aop;
        logic       ill, done;
    } out_t;

    typedef struct {
        string      nm;
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic       mr;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pcsrc;
    logic       reg_we, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, aluop;
    logic       illegal, instr_done;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pcsrc(pcsrc),
        .reg_we(reg_we), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .illegal(illegal), .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    out_t got;
    assign got = {state, mem_req, mem_we, iord, ir_we, pc_we, pcsrc,
                  reg_we, regdst, memtoreg, alusrca, alusrcb, aluop,
                  illegal, instr_done};

    function automatic out_t o(
        input logic [3:0] st, input logic mreq, mwe, io, irw, pcw,
        input logic [1:0] ps, input logic rw, rd, m2, sa,
        input logic [1:0] sb, ao, input logic il, dn);
        return {st, mreq, mwe, io, irw, pcw, ps, rw, rd, m2, sa, sb, ao, il, dn};
    endfunction

    out_t X_F1, X_F0, X_D, X_DI, X_A, X_RD, X_WB, X_WR0, X_WR1, X_EX;
    out_t X_AW, X_BR1, X_BR0, X_AX, X_AWB, X_J, X_RST, X_RST_RD;

    vec_t vecs[$];

    task automatic add(input string nm, input logic rst, input logic [5:0] op,
                       input logic z, input logic mr, input out_t e);
        vec_t v;
        v.nm = nm; v.rst = rst; v.op = op; v.z = z; v.mr = mr; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input out_t e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nm, got, e);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h05 ||
               op == 6'h08 || op == 6'h23 || op == 6'h2b;
    endfunction

    // Expected outputs for one cycle, given which phase of the instruction we are in.
    function automatic out_t model(input int ph, input logic rst, input logic mr,
                                   input logic z, input logic [5:0] op);
        out_t e;
        e = '0;
        case (ph)
            0:  e = mr ? X_F1 : X_F0;
            1:  e = legal(op) ? X_D : X_DI;
            2:  e = X_A;
            3:  e = X_RD;
            4:  e = X_WB;
            5:  e = mr ? X_WR1 : X_WR0;
            6:  e = X_EX;
            7:  e = X_AW;
            8:  e = ((op == 6'h05) ? !z : z) ? X_BR1 : X_BR0;
            9:  e = X_AX;
            10: e = X_AWB;
            11: e = X_J;
            default: e = '0;
        endcase
        if (rst) begin
            e.mreq = 0; e.mwe = 0; e.irwe = 0; e.pcwe = 0;
            e.regwe = 0; e.ill = 0; e.done = 0;
        end
        return e;
    endfunction

    int         plan[$];
    logic [5:0] cur_op;

    task automatic start_instr();
        int r;
        r = $urandom_range(0, 8);
        case (r)
            0: cur_op = 6'h00;
            1: cur_op = 6'h02;
            2: cur_op = 6'h04;
            3: cur_op = 6'h05;
            4: cur_op = 6'h08;
            5: cur_op = 6'h23;
            6: cur_op = 6'h2b;
            default: cur_op = 6'($urandom());
        endcase
        plan = {0, 1};
        case (cur_op)
            6'h23: plan = {plan, 2, 3, 4};
            6'h2b: plan = {plan, 2, 5};
            6'h00: plan = {plan, 6, 7};
            6'h08: plan = {plan, 9, 10};
            6'h04, 6'h05: plan.push_back(8);
            6'h02: plan.push_back(11);
            default: ;
        endcase
    endtask

    initial begin
        logic [6:0] en;
        logic rst_v, mr_v, z_v;
        int ph;

        X_F1  = o(0, 1,0,0,1,1, 0, 0,0,0, 0,1,0, 0,0);
        X_F0  = o(0, 1,0,0,0,0, 0, 0,0,0, 0,1,0, 0,0);
        X_D   = o(1, 0,0,0,0,0, 0, 0,0,0, 0,3,0, 0,0);
        X_DI  = o(1, 0,0,0,0,0, 0, 0,0,0, 0,3,0, 1,1);
        X_A   = o(2, 0,0,0,0,0, 0, 0,0,0, 1,2,0, 0,0);
        X_RD  = o(3, 1,0,1,0,0, 0, 0,0,0, 0,0,0, 0,0);
        X_WB  = o(4, 0,0,0,0,0, 0, 1,0,1, 0,0,0, 0,1);
        X_WR0 = o(5, 1,1,1,0,0, 0, 0,0,0, 0,0,0, 0,0);
        X_WR1 = o(5, 1,1,1,0,0, 0, 0,0,0, 0,0,0, 0,1);
        X_EX  = o(6, 0,0,0,0,0, 0, 0,0,0, 1,0,2, 0,0);
        X_AW  = o(7, 0,0,0,0,0, 0, 1,1,0, 0,0,0, 0,1);
        X_BR1 = o(8, 0,0,0,0,1, 1, 0,0,0, 1,0,1, 0,1);
        X_BR0 = o(8, 0,0,0,0,0, 1, 0,0,0, 1,0,1, 0,1);
        X_AX  = o(9, 0,0,0,0,0, 0, 0,0,0, 1,2,0, 0,0);
        X_AWB = o(10,0,0,0,0,0, 0, 1,0,0, 0,0,0, 0,1);
        X_J   = o(11,0,0,0,0,1, 2, 0,0,0, 0,0,0, 0,1);
        X_RST = o(0, 0,0,0,0,0, 0, 0,0,0, 0,1,0, 0,0);
        X_RST_RD = o(3, 0,0,1,0,0, 0, 0,0,0, 0,0,0, 0,0);

        add("rst2",    1, 6'h00, 0, 1, X_RST);
        add("lw_f",    0, 6'h23, 0, 1, X_F1);
        add("lw_d",    0, 6'h23, 0, 1, X_D);
        add("lw_a",    0, 6'h23, 0, 1, X_A);
        add("lw_rd",   0, 6'h23, 0, 1, X_RD);
        add("lw_wb",   0, 6'h23, 0, 1, X_WB);
        add("sw_f",    0, 6'h2b, 0, 1, X_F1);
        add("sw_d",    0, 6'h2b, 0, 1, X_D);
        add("sw_a",    0, 6'h2b, 0, 1, X_A);
        add("sw_wait1",0, 6'h2b, 0, 0, X_WR0);
        add("sw_wait2",0, 6'h2b, 0, 0, X_WR0);
        add("sw_wr",   0, 6'h2b, 0, 1, X_WR1);
        add("beq1_f",  0, 6'h04, 1, 1, X_F1);
        add("beq1_d",  0, 6'h04, 1, 1, X_D);
        add("beq1_br", 0, 6'h04, 1, 1, X_BR1);
        add("beq0_f",  0, 6'h04, 0, 1, X_F1);
        add("beq0_d",  0, 6'h04, 0, 1, X_D);
        add("beq0_br", 0, 6'h04, 0, 1, X_BR0);
        add("bne1_f",  0, 6'h05, 1, 1, X_F1);
        add("bne1_d",  0, 6'h05, 1, 1, X_D);
        add("bne1_br", 0, 6'h05, 1, 1, X_BR0);
        add("bne0_f",  0, 6'h05, 0, 1, X_F1);
        add("bne0_d",  0, 6'h05, 0, 1, X_D);
        add("bne0_br", 0, 6'h05, 0, 1, X_BR1);
        add("ill_f",   0, 6'h3f, 0, 1, X_F1);
        add("ill_d",   0, 6'h3f, 0, 1, X_DI);
        add("addi_f",  0, 6'h08, 0, 1, X_F1);
        add("addi_d",  0, 6'h08, 0, 1, X_D);
        add("addi_ex", 0, 6'h08, 0, 1, X_AX);
        add("addi_wb", 0, 6'h08, 0, 1, X_AWB);
        add("j_fwait", 0, 6'h02, 0, 0, X_F0);
        add("j_f",     0, 6'h02, 0, 1, X_F1);
        add("j_d",     0, 6'h02, 0, 1, X_D);
        add("j_j",     0, 6'h02, 0, 1, X_J);
        add("lwr_f",   0, 6'h23, 0, 1, X_F1);
        add("lwr_d",   0, 6'h23, 0, 1, X_D);
        add("lwr_a",   0, 6'h23, 0, 1, X_A);
        add("lwr_rd",  0, 6'h23, 0, 0, X_RD);
        add("lwr_rst", 1, 6'h23, 0, 0, X_RST_RD);
        add("r_f",     0, 6'h00, 0, 1, X_F1);
        add("r_d",     0, 6'h00, 0, 1, X_D);
        add("r_ex",    0, 6'h00, 0, 1, X_EX);
        add("r_wb",    0, 6'h00, 0, 1, X_AW);

        // First reset cycle: state is unknown, only the forced enables are defined.
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b1;
        #1;
        en = {mem_req, mem_we, ir_we, pc_we, reg_we, illegal, instr_done};
        checks++;
        if (en !== 7'b0) begin
            errors++;
            $display("FAIL rst_en: got=%b expected=%b", en, 7'b0);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; opcode = vecs[i].op;
            zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            check(vecs[i].nm, vecs[i].exp);
        end

        start_instr();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_v = ($urandom_range(0, 49) == 0);
            mr_v  = ($urandom_range(0, 2) != 0);
            z_v   = 1'($urandom_range(0, 1));
            reset = rst_v; mem_ready = mr_v; zero = z_v; opcode = cur_op;
            #1;
            ph = plan[0];
            check($sformatf("rand c=%0d ph=%0d op=%h", c, ph, cur_op),
                  model(ph, rst_v, mr_v, z_v, cur_op));
            if (rst_v) begin
                start_instr();
            end else if (!((ph == 0 || ph == 3 || ph == 5) && !mr_v)) begin
                void'(plan.pop_front());
                if (plan.size() == 0) start_instr();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
